capture_sequencer: RTL and testbench

- Per-spill controller for a bank of sticky capture flags: detects the spill start on the `live` gate, clears all flags, and collects `get` events per channel during the spill.
- At spill end, freezes the captured set and drains it one channel index at a time over a valid/ready readout port shared by all channels.
- Sits between the trigger-side event sources and the readout/DAQ interface.

---
 rtl/capture_sequencer_pkg.sv | 24 ++
 rtl/capture_sequencer_if.sv | 34 +++
 rtl/capture_prio_enc.sv | 23 ++
 rtl/capture_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/capture_sequencer_pkg.sv
// capture_pkg: shared types and constants for the capture sequencer.
//   state_t   : sequencer FSM states (IDLE, LIVE, DRAIN)
//   ch_w()    : ceil(log2(n)) with a minimum of 1, sizes the channel index
//   *_DEF     : default parameter widths
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LIVE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int N_CH_DEF  = 8;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  function automatic int ch_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: readout port shared by all capture channels.
//   rd_valid : entry valid (master -> slave)
//   rd_ready : consumer ready (slave -> master)
//   rd_ch    : captured channel index
//   rd_ts    : first-hit timestamp, present only with CAPTURE_TS_EN
// Handshake: an entry transfers on every clock edge where rd_valid and
// rd_ready are both high; while rd_valid is high and rd_ready is low the
// master holds rd_ch/rd_ts stable; rd_valid never depends on rd_ready.
interface capture_sequencer_if
  import capture_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
`ifdef CAPTURE_TS_EN
  , parameter int TS_W = TS_W_DEF
`endif
);
  localparam int CH_W = ch_w(N_CH);

  logic            rd_valid;
  logic            rd_ready;
  logic [CH_W-1:0] rd_ch;
`ifdef CAPTURE_TS_EN
  logic [TS_W-1:0] rd_ts;
`endif

`ifdef CAPTURE_TS_EN
  modport master (output rd_valid, output rd_ch, output rd_ts, input rd_ready);
  modport slave  (input rd_valid, input rd_ch, input rd_ts, output rd_ready);
`else
  modport master (output rd_valid, output rd_ch, input rd_ready);
  modport slave  (input rd_valid, input rd_ch, output rd_ready);
`endif

endinterface

// File: rtl/capture_prio_enc.sv
// capture_prio_enc: combinational lowest-set-bit encoder.
//   req : N_CH request bits
//   idx : index of the lowest set bit (0 when none set)
//   any : at least one bit set
module capture_prio_enc #(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] req,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = CH_W'(i);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: per-spill controller for a bank of sticky capture flags.
// A rising edge on live (seen in IDLE) starts a spill and clears the flags;
// get events are collected while LIVE; the falling edge snapshots the flags
// and the set is drained lowest index first over the rd port.
// Optional feature macro: CAPTURE_TS_EN (per-channel first-hit timestamps).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   live        : spill gate level (synchronous)
//   get         : per-channel capture events
//   rd          : readout port (capture_sequencer_if.master)
//   busy        : state is LIVE or DRAIN
//   spill_done  : one-cycle pulse when a drain completes
//   overrun     : sticky, a spill started while draining
//   spill_cnt   : accepted spill counter (wraps)
//   dbg_state   : current FSM state
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
`ifdef CAPTURE_TS_EN
  parameter int TS_W = TS_W_DEF,
`endif
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live,
  input  logic [N_CH-1:0]   get,
  capture_sequencer_if.master rd,
  output logic              busy,
  output logic              spill_done,
  output logic              overrun,
  output logic [CNT_W-1:0]  spill_cnt,
  output state_t            dbg_state
);

  localparam int CH_W = ch_w(N_CH);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   flags_q, flags_d;
  logic [N_CH-1:0]   pend_q, pend_d, pend_nxt;
  logic              live_d_q;
  logic              rd_valid_q, rd_valid_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic              busy_q, busy_d;
  logic              spill_done_q, spill_done_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  spill_cnt_q, spill_cnt_d;
  logic              rise, fall;
  logic [CH_W-1:0]   enc_idx;
  logic              enc_any;

  assign rise = live & ~live_d_q;
  assign fall = ~live & live_d_q;

  // Pending set after this cycle's transfer; the encoder looks ahead so the
  // next entry is presented the cycle right after a handshake.
  always_comb begin
    pend_nxt = pend_q;
    if (rd_valid_q && rd.rd_ready) pend_nxt = pend_q & ~(N_CH'(1) << rd_ch_q);
  end

  capture_prio_enc #(.N_CH(N_CH), .CH_W(CH_W)) u_enc (
    .req (pend_nxt),
    .idx (enc_idx),
    .any (enc_any)
  );

`ifdef CAPTURE_TS_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] ts_q [N_CH];
  logic [TS_W-1:0] ts_d [N_CH];
  logic [TS_W-1:0] rd_ts_q, rd_ts_d;
`endif

  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    pend_d       = pend_q;
    rd_valid_d   = rd_valid_q;
    rd_ch_d      = rd_ch_q;
    spill_done_d = 1'b0;
    overrun_d    = overrun_q;
    spill_cnt_d  = spill_cnt_q;
`ifdef CAPTURE_TS_EN
    ts_cnt_d = ts_cnt_q;
    ts_d     = ts_q;
    rd_ts_d  = rd_ts_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          // Clear and capture in one step: a get in the rise cycle survives.
          flags_d     = get;
          spill_cnt_d = spill_cnt_q + CNT_W'(1);
          state_d     = LIVE;
`ifdef CAPTURE_TS_EN
          ts_cnt_d = '0;
          for (int i = 0; i < N_CH; i++) if (get[i]) ts_d[i] = '0;
`endif
        end
      end
      LIVE: begin
        flags_d = flags_q | get;
`ifdef CAPTURE_TS_EN
        ts_cnt_d = (ts_cnt_q == '1) ? ts_cnt_q : ts_cnt_q + TS_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          if (get[i] && !flags_q[i]) ts_d[i] = ts_cnt_d;
        end
`endif
        if (fall) begin
          pend_d  = flags_q | get;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rise) overrun_d = 1'b1;
        pend_d = pend_nxt;
        if (enc_any) begin
          rd_valid_d = 1'b1;
          rd_ch_d    = enc_idx;
`ifdef CAPTURE_TS_EN
          rd_ts_d = ts_q[enc_idx];
`endif
        end else begin
          rd_valid_d   = 1'b0;
          spill_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flags_q      <= '0;
      pend_q       <= '0;
      live_d_q     <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_ch_q      <= '0;
      busy_q       <= 1'b0;
      spill_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      spill_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      pend_q       <= pend_d;
      live_d_q     <= live;
      rd_valid_q   <= rd_valid_d;
      rd_ch_q      <= rd_ch_d;
      busy_q       <= busy_d;
      spill_done_q <= spill_done_d;
      overrun_q    <= overrun_d;
      spill_cnt_q  <= spill_cnt_d;
    end
  end

`ifdef CAPTURE_TS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      rd_ts_q  <= '0;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      rd_ts_q  <= rd_ts_d;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= ts_d[i];
    end
  end
  assign rd.rd_ts = rd_ts_q;
`endif

  assign rd.rd_valid  = rd_valid_q;
  assign rd.rd_ch     = rd_ch_q;
  assign busy         = busy_q;
  assign spill_done   = spill_done_q;
  assign overrun      = overrun_q;
  assign spill_cnt    = spill_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed self-checking bench for capture_sequencer.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
module tb_capture_sequencer;
  import capture_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        live = 1'b0;
  logic [7:0]  get = '0;
  logic        busy, spill_done, overrun;
  logic [15:0] spill_cnt;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_ch;

  capture_sequencer_if rd_if ();

  capture_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .live       (live),
    .get        (get),
    .rd         (rd_if),
    .busy       (busy),
    .spill_done (spill_done),
    .overrun    (overrun),
    .spill_cnt  (spill_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; live = 1'b1; get = '0; rd_if.rd_ready = 1'b1;
    step(2);
    n_tests++; if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_if.rd_valid); end
    n_tests++; if (rd_if.rd_ch !== 3'd0) begin n_fail++; $display("FAIL reset_rd_ch: got %0d want 0", rd_if.rd_ch); end
    n_tests++; if ({busy, spill_done, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, spill_done, overrun}); end
    n_tests++; if (spill_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_spill_cnt: got %0d want 0", spill_cnt); end
    // live already high at release must not start a spill
    rst_n = 1'b1;
    step(3);
    n_tests++; if (dbg_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL reset_live_high: state %0d busy %b want IDLE/0", dbg_state, busy); end
    n_tests++; if (spill_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_live_high_cnt: got %0d want 0", spill_cnt); end
    live = 1'b0;
    step(2);
  endtask

  task automatic test_spill_basic;
    get = 8'h40;                     // idle get must be ignored
    step(8);
    get = '0; live = 1'b1;
    step(1);
    exp_cnt++;
    n_tests++; if (dbg_state !== LIVE || busy !== 1'b1) begin n_fail++; $display("FAIL basic_live: state %0d busy %b want LIVE/1", dbg_state, busy); end
    n_tests++; if (spill_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", spill_cnt, exp_cnt); end
    step(9);  get = 8'h08; step(1); get = '0;
    step(9);  get = 8'h20; step(1); get = '0;
    step(19); live = 1'b0;
    step(1);
    n_tests++; if (dbg_state !== DRAIN || rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_entry: state %0d valid %b want DRAIN/0", dbg_state, rd_if.rd_valid); end
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd3) begin n_fail++; $display("FAIL basic_first: valid %b ch %0d want 1/3", rd_if.rd_valid, rd_if.rd_ch); end
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd5) begin n_fail++; $display("FAIL basic_second: valid %b ch %0d want 1/5", rd_if.rd_valid, rd_if.rd_ch); end
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b0 || spill_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: valid %b done %b busy %b want 0/1/0", rd_if.rd_valid, spill_done, busy); end
    step(1);
    n_tests++; if (spill_done !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL basic_done_pulse: done %b state %0d want 0/IDLE", spill_done, dbg_state); end
  endtask

  task automatic test_collision;
    live = 1'b1; step(1); exp_cnt++;
    get = 8'h80; step(1); get = '0;
    live = 1'b0; step(2);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd7) begin n_fail++; $display("FAIL coll_prev: valid %b ch %0d want 1/7", rd_if.rd_valid, rd_if.rd_ch); end
    step(2);
    live = 1'b1; get = 8'h01; step(1); exp_cnt++;
    get = '0; live = 1'b0; step(2);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd0) begin n_fail++; $display("FAIL coll_ch0: valid %b ch %0d want 1/0", rd_if.rd_valid, rd_if.rd_ch); end
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b0 || spill_done !== 1'b1) begin n_fail++; $display("FAIL coll_only0: valid %b done %b want 0/1", rd_if.rd_valid, spill_done); end
    n_tests++; if (spill_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL coll_cnt: got %0d want %0d", spill_cnt, exp_cnt); end
    step(1);
  endtask

  task automatic test_backpressure;
    rd_if.rd_ready = 1'b0;
    live = 1'b1; step(1); exp_cnt++;
    get = 8'h52; step(1); get = '0;
    live = 1'b0; step(2);
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd1) begin n_fail++; $display("FAIL bp_hold_%0d: valid %b ch %0d want 1/1", i, rd_if.rd_valid, rd_if.rd_ch); end
      step(1);
    end
    exp_q = '{3'd1, 3'd4, 3'd6};
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 10 && spill_done !== 1'b1; i++) begin
      if (rd_if.rd_valid === 1'b1) begin
        exp_ch = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        n_tests++; if (rd_if.rd_ch !== exp_ch) begin n_fail++; $display("FAIL bp_order: got %0d want %0d", rd_if.rd_ch, exp_ch); end
      end
      step(1);
    end
    n_tests++; if (spill_done !== 1'b1 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_complete: done %b left %0d want 1/0", spill_done, exp_q.size()); end
    step(1);
  endtask

  task automatic test_empty_and_fall_event;
    live = 1'b1; step(1); exp_cnt++;
    step(3);
    live = 1'b0; step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b0 || spill_done !== 1'b0) begin n_fail++; $display("FAIL empty_entry: valid %b done %b want 0/0", rd_if.rd_valid, spill_done); end
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b0 || spill_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: valid %b done %b want 0/1", rd_if.rd_valid, spill_done); end
    step(2);
    live = 1'b1; step(1); exp_cnt++;
    step(2);
    live = 1'b0; get = 8'h04; step(1); get = '0;
    step(1);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd2) begin n_fail++; $display("FAIL fall_event: valid %b ch %0d want 1/2", rd_if.rd_valid, rd_if.rd_ch); end
    step(1);
    n_tests++; if (spill_done !== 1'b1) begin n_fail++; $display("FAIL fall_event_done: got %b want 1", spill_done); end
    step(1);
  endtask

  task automatic test_overrun;
    rd_if.rd_ready = 1'b0;
    live = 1'b1; step(1); exp_cnt++;
    get = 8'h8D; step(1); get = '0;
    live = 1'b0; step(1);
    live = 1'b1; step(1);            // rise while draining
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    n_tests++; if (spill_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ovr_cnt: got %0d want %0d", spill_cnt, exp_cnt); end
    exp_q = '{3'd0, 3'd2, 3'd3, 3'd7};
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 12 && spill_done !== 1'b1; i++) begin
      if (rd_if.rd_valid === 1'b1) begin
        exp_ch = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        n_tests++; if (rd_if.rd_ch !== exp_ch) begin n_fail++; $display("FAIL ovr_order: got %0d want %0d", rd_if.rd_ch, exp_ch); end
      end
      step(1);
    end
    n_tests++; if (spill_done !== 1'b1 || exp_q.size() != 0) begin n_fail++; $display("FAIL ovr_complete: done %b left %0d want 1/0", spill_done, exp_q.size()); end
    step(2);                          // live still high: must stay IDLE
    n_tests++; if (dbg_state !== IDLE || spill_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ovr_no_restart: state %0d cnt %0d want IDLE/%0d", dbg_state, spill_cnt, exp_cnt); end
    live = 1'b0; step(1);
    live = 1'b1; step(1); exp_cnt++;
    n_tests++; if (dbg_state !== LIVE || spill_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ovr_fresh: state %0d cnt %0d want LIVE/%0d", dbg_state, spill_cnt, exp_cnt); end
    live = 1'b0; step(3);
    n_tests++; if (overrun !== 1'b1 || dbg_state !== IDLE) begin n_fail++; $display("FAIL ovr_sticky: ovr %b state %0d want 1/IDLE", overrun, dbg_state); end
  endtask

`ifdef CAPTURE_TS_EN
  task automatic test_timestamp;
    rd_if.rd_ready = 1'b1;
    live = 1'b1; step(1); exp_cnt++;   // edge t0
    step(11);
    get = 8'h02; step(1); get = '0;    // edge t0+12
    step(27);
    get = 8'h02; step(1); get = '0;    // edge t0+40
    live = 1'b0; step(2);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd1 || rd_if.rd_ts !== 16'd12) begin n_fail++; $display("FAIL ts_first_hit: valid %b ch %0d ts %0d want 1/1/12", rd_if.rd_valid, rd_if.rd_ch, rd_if.rd_ts); end
    step(2);
  endtask
`endif

  task automatic test_reset_mid_drain;
    rd_if.rd_ready = 1'b0;
    live = 1'b1; step(1);
    get = 8'h0C; step(1); get = '0;
    live = 1'b0; step(2);
    n_tests++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_ch !== 3'd2) begin n_fail++; $display("FAIL rst_pre: valid %b ch %0d want 1/2", rd_if.rd_valid, rd_if.rd_ch); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_ch !== 3'd0 || busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_async: valid %b ch %0d busy %b state %0d want 0/0/0/IDLE", rd_if.rd_valid, rd_if.rd_ch, busy, dbg_state); end
    n_tests++; if (spill_cnt !== 16'd0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_counters: cnt %0d ovr %b want 0/0", spill_cnt, overrun); end
`ifdef CAPTURE_TS_EN
    n_tests++; if (rd_if.rd_ts !== 16'd0) begin n_fail++; $display("FAIL rst_ts: got %0d want 0", rd_if.rd_ts); end
`endif
    step(1);
    rst_n = 1'b1; rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_tests++; if (spill_done !== 1'b0 || rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped_%0d: done %b valid %b want 0/0", i, spill_done, rd_if.rd_valid); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rd_if.rd_ready = 1'b1;
    test_reset();
    test_spill_basic();
    test_collision();
    test_backpressure();
    test_empty_and_fall_event();
    test_overrun();
`ifdef CAPTURE_TS_EN
    test_timestamp();
`endif
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
